// File: rtl/collision_scan.sv
// Scans a tile table once per start and reports which sides of the player sprite
// touch an enabled tile, how many tiles touched, and the first tile landed on.
module collision_scan #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int PW      = 23,
    parameter int PH      = 45,
    parameter int TW      = 25,
    parameter int TH      = 24,
    parameter int MARGIN  = 2,
    parameter int N_TILES = 16,
    parameter int IW      = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x_player,
    input  logic [YW-1:0] y_player,
    output logic [IW-1:0] tile_idx,
    input  logic [XW-1:0] tile_x,
    input  logic [YW-1:0] tile_y,
    input  logic          tile_en,
    output logic          busy,
    output logic          done,
    output logic [3:0]    is_Collision,
    output logic [IW:0]   hit_count,
    output logic [IW-1:0] land_idx,
    output logic          land_valid
);
    localparam int X1 = XW + 1;
    localparam int Y1 = YW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_TILES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t        state_reg;
    logic [XW-1:0] xp_reg;
    logic [YW-1:0] yp_reg;
    logic          samp_vld_reg;
    logic [IW-1:0] samp_idx_reg;
    logic [3:0]    acc_side_reg;
    logic [IW:0]   acc_cnt_reg;
    logic [IW-1:0] acc_land_idx_reg;
    logic          acc_land_vld_reg;

    // One extra bit on every sum keeps the comparisons free of wraparound.
    logic [X1-1:0] xp_pw, xp_mg, xp_w, xt_mg, xt_tw, xt_w;
    logic [Y1-1:0] yp_ph, yp_mg, yp_w, yt_mg, yt_th, yt_w;
    logic          hx, vy;
    logic [3:0]    sides;

    assign xp_w  = X1'(xp_reg);
    assign yp_w  = Y1'(yp_reg);
    assign xt_w  = X1'(tile_x);
    assign yt_w  = Y1'(tile_y);
    assign xp_pw = xp_w + X1'(PW);
    assign xp_mg = xp_w + X1'(MARGIN);
    assign xt_mg = xt_w + X1'(MARGIN);
    assign xt_tw = xt_w + X1'(TW);
    assign yp_ph = yp_w + Y1'(PH);
    assign yp_mg = yp_w + Y1'(MARGIN);
    assign yt_mg = yt_w + Y1'(MARGIN);
    assign yt_th = yt_w + Y1'(TH);

    assign hx = (xp_pw > xt_mg) && (xp_mg < xt_tw);
    assign vy = (yp_ph > yt_mg) && (yp_mg < yt_th);

    assign sides = {vy && (xp_w == xt_tw),
                    vy && (xp_pw == xt_w),
                    hx && (yp_w == yt_th),
                    hx && (yp_ph == yt_w)} & {4{tile_en && samp_vld_reg}};

    logic [3:0]    side_next;
    logic [IW:0]   cnt_next;
    logic [IW-1:0] land_idx_next;
    logic          land_vld_next;

    always_comb begin
        side_next     = acc_side_reg | sides;
        cnt_next      = acc_cnt_reg;
        land_idx_next = acc_land_idx_reg;
        land_vld_next = acc_land_vld_reg;
        if (|sides) begin
            cnt_next = acc_cnt_reg + (IW+1)'(1);
        end
        if (sides[0] && !acc_land_vld_reg) begin
            land_idx_next = samp_idx_reg;
            land_vld_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            xp_reg           <= '0;
            yp_reg           <= '0;
            samp_vld_reg     <= 1'b0;
            samp_idx_reg     <= '0;
            acc_side_reg     <= '0;
            acc_cnt_reg      <= '0;
            acc_land_idx_reg <= '0;
            acc_land_vld_reg <= 1'b0;
            tile_idx         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            is_Collision     <= '0;
            hit_count        <= '0;
            land_idx         <= '0;
            land_valid       <= 1'b0;
        end else begin
            // Read data lags the address by one cycle, so remember what was asked for.
            samp_vld_reg <= (state_reg == SCAN);
            samp_idx_reg <= tile_idx;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        xp_reg           <= x_player;
                        yp_reg           <= y_player;
                        acc_side_reg     <= '0;
                        acc_cnt_reg      <= '0;
                        acc_land_idx_reg <= '0;
                        acc_land_vld_reg <= 1'b0;
                        tile_idx         <= '0;
                        busy             <= 1'b1;
                        state_reg        <= SCAN;
                    end
                end
                SCAN: begin
                    acc_side_reg     <= side_next;
                    acc_cnt_reg      <= cnt_next;
                    acc_land_idx_reg <= land_idx_next;
                    acc_land_vld_reg <= land_vld_next;
                    if (tile_idx == LAST_IDX) begin
                        state_reg <= DRAIN;
                    end else begin
                        tile_idx <= tile_idx + IW'(1);
                    end
                end
                DRAIN: begin
                    is_Collision <= side_next;
                    hit_count    <= cnt_next;
                    land_idx     <= land_idx_next;
                    land_valid   <= land_vld_next;
                    done         <= 1'b1;
                    state_reg    <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/collision_scan.md
COLLISION_SCAN -- requirements
Module: collision_scan

Interface
REQ-001 The block SHALL have these parameters:
- XW, 10, x coordinate width
- YW, 9, y coordinate width
- PW, 23, player sprite width in pixels
- PH, 45, player sprite height in pixels
- TW, 25, tile width in pixels
- TH, 24, tile height in pixels
- MARGIN, 2, corner-forgiveness margin in pixels
- N_TILES, 16, number of tile slots scanned per pass (>=1)
- IW, $clog2(N_TILES) (min 1), tile index width
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request one scan pass
- x_player  in  XW  player top-left x
- y_player  in  YW  player top-left y
- tile_idx  out  IW  tile table read address
- tile_x  in  XW  tile top-left x; valid one cycle after tile_idx
- tile_y  in  YW  tile top-left y; valid one cycle after tile_idx
- tile_en  in  1  tile slot occupied; valid one cycle after tile_idx
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at end of pass
- is_Collision  out  4  [0] down, [1] up, [2] right, [3] left
- hit_count  out  IW+1  number of enabled tiles that set any side bit
- land_idx  out  IW  lowest tile index that set bit 0
- land_valid  out  1  land_idx is meaningful

Function
REQ-003 FSM states SHALL be IDLE, SCAN, DRAIN and DONE.
REQ-004 In IDLE, start=1 SHALL latch x_player and y_player, clear the internal accumulators, drive tile_idx=0 and enter SCAN; busy SHALL be 1 from the next cycle until DONE exits.
REQ-005 In SCAN, tile_idx SHALL advance by 1 per cycle through 0..N_TILES-1; after N_TILES-1 the FSM SHALL enter DRAIN.
REQ-006 Tile data for index i SHALL be sampled on the edge one cycle after tile_idx=i; DRAIN SHALL exist only to sample the last index.
REQ-007 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE; start-to-done latency SHALL be N_TILES+2 edges.
REQ-008 The side tests against the latched player position SHALL be:
- hx = (xp+PW > xt+MARGIN) and (xp+MARGIN < xt+TW)
- vy = (yp+PH > yt+MARGIN) and (yp+MARGIN < yt+TH)
- down = hx and (yp+PH == yt)
- up = hx and (yp == yt+TH)
- right = vy and (xp+PW == xt)
- left = vy and (xp == xt+TW)
REQ-009 All sums SHALL be evaluated one bit wider than the operands, so that no comparison wraps; no subtraction SHALL be used.
REQ-010 A tile sampled with tile_en=0 SHALL contribute nothing.
REQ-011 The per-side results SHALL be OR-accumulated across the pass; hit_count SHALL increment once per tile with any side true.
REQ-012 For land_idx, the first (lowest-index) tile with down=1 SHALL be recorded, and later tiles SHALL NOT overwrite it.
REQ-013 is_Collision, hit_count, land_idx and land_valid SHALL update only on the edge that enters DONE, and SHALL hold their values between passes.
REQ-014 start SHALL be ignored while busy=1 or in DONE; start held high SHALL begin a new pass on the cycle after DONE.
REQ-015 Changes to x_player and y_player during a pass SHALL NOT affect that pass.
REQ-016 With N_TILES=1, SCAN SHALL last one cycle and DRAIN SHALL follow directly.

Reset
REQ-017 rst=1 at any edge, including mid-pass, SHALL force IDLE and set tile_idx=0, busy=0, done=0, is_Collision=0, hit_count=0, land_idx=0 and land_valid=0; an aborted pass SHALL produce no done.
REQ-018 rst SHALL take priority over start on the same edge.

Verification
REQ-019 (defaults, N_TILES=4, tiles 1-3 disabled) player (100,55), tile0 (110,100), start -> done 6 edges after start, is_Collision=0001, hit_count=1, land_idx=0, land_valid=1.
REQ-020 tile0 (110,100): player (100,124) -> 0010; player (87,80) -> 0100; player (135,80) -> 1000; each with hit_count=1.
REQ-021 player (76,55), tile0 (110,100) (grazing corner, 99>112 false) -> is_Collision=0000, land_valid=0.
REQ-022 tiles 1 and 3 both satisfy down, tile2 satisfies left, tile0 disabled -> is_Collision=1001, hit_count=3, land_idx=1.
REQ-023 Assert rst during SCAN at tile_idx=2 -> all outputs 0 next cycle, no done pulse; a new start completes normally.
REQ-024 Pulse start every cycle and move the player mid-pass -> passes are back-to-back with no overlap, and results reflect only the positions latched at each start.
